penc_scan: RTL and testbench

PENC_SCAN -- requirements
Module: penc_scan

---
 rtl/penc_pkg.sv | 19 +
 rtl/penc_find.sv | 40 ++++
 rtl/penc_scan.sv | 94 +++++++++
 tb/tb_penc_scan.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/penc_pkg.sv
// Shared types and helpers for the penc_scan priority-encoder scanner.
package penc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Bits needed to hold an index in 0..n-1 (n >= 2).
    function automatic int penc_clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/penc_find.sv
// Circular downward search: first set bit of vec at or below start, wrapping to N-1.
module penc_find
    import penc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = penc_clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic         lo_hit;
    logic         wr_hit;
    logic [W-1:0] lo_idx;
    logic [W-1:0] wr_idx;

    // Highest set bit at or below start wins; otherwise the highest above it.
    always_comb begin
        lo_hit = 1'b0;
        wr_hit = 1'b0;
        lo_idx = '0;
        wr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                if (i <= int'(start)) begin
                    lo_hit = 1'b1;
                    lo_idx = W'(i);
                end else begin
                    wr_hit = 1'b1;
                    wr_idx = W'(i);
                end
            end
        end
        idx   = lo_hit ? lo_idx : wr_idx;
        found = lo_hit | wr_hit;
    end

endmodule

// File: rtl/penc_scan.sv
// Load a request vector, then hand out each set index once over a valid/ready port.
// Define PENC_ROUND_ROBIN_EN to scan downward from the last served index instead of bit N-1.
module penc_scan
    import penc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = penc_clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] D,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         zero
);

    state_e       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         zero_q, zero_d;
    logic [W-1:0] start;
    logic [W-1:0] f_idx;
    logic         f_found;

`ifdef PENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    assign start = (ptr_q == '0) ? W'(N - 1) : ptr_q - W'(1);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == SCAN && out_ready && f_found) ptr_d = f_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    assign start = W'(N - 1);
`endif

    penc_find #(.N(N)) u_find (
        .vec   (pend_q),
        .start (start),
        .idx   (f_idx),
        .found (f_found)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zero_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (D != '0) begin
                        pend_d  = D;
                        state_d = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready && f_found) begin
                    pend_d = pend_q & ~(N'(1) << f_idx);
                    if (pend_d == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SCAN);
    assign Y         = out_valid ? f_idx : '0;
    assign zero      = zero_q;

endmodule

// File: tb/tb_penc_scan.sv
// Bench for penc_scan (N=8): directed sequences plus a vector table and random loads.
module tb_penc_scan;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [N-1:0] D;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         zero;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mptr = 0;

    always #5 clk = ~clk;

    penc_scan #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .D         (D),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .zero      (zero)
    );

    typedef struct {
        logic [N-1:0] d;
        int           pct;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int mfind(input logic [N-1:0] v, input int s);
        int p;
        for (int k = 0; k < N; k++) begin
            p = (s - k + N) % N;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    // Expected serve order of a load, queued at the moment it is driven.
    task automatic push_model(input logic [N-1:0] d);
        logic [N-1:0] v;
        int s, p;
        v = d;
        while (v != '0) begin
`ifdef PENC_ROUND_ROBIN_EN
            s = (mptr == 0) ? N - 1 : mptr - 1;
`else
            s = N - 1;
`endif
            p = mfind(v, s);
            exp_q.push_back(p);
            v[p] = 1'b0;
            mptr = p;
        end
    endtask

    task automatic do_load(input logic [N-1:0] d);
        check("load_ready", in_ready, 1);
        load = 1'b1;
        D    = d;
        if (d != '0) push_model(d);
        tick();
        load = 1'b0;
        check("valid_lat1", out_valid, d != '0);
        check("zero_pulse", zero, d == '0);
    endtask

    task automatic drain(input int pct, output int hs);
        int n;
        hs = 0;
        n  = 0;
        while (out_valid === 1'b1 && n < 200) begin
            out_ready = ($urandom_range(99) < pct);
            load      = 1'($urandom_range(1));
            D         = N'($urandom);
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else if (out_ready) begin
                hs++;
                check("y_order", Y, exp_q.pop_front());
            end else begin
                check("y_stall", Y, exp_q[0]);
            end
            tick();
            n++;
        end
        load      = 1'b0;
        out_ready = 1'b0;
        if (n >= 200) check("drain_timeout", 1, 0);
        check("idle_ready", in_ready, 1);
        check("idle_y", Y, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   exp36[4];
        int   hs;
        logic [N-1:0] d;

        tbl[0] = '{8'hA6, 100};
        tbl[1] = '{8'h81, 30};
        tbl[2] = '{8'hFF, 50};
        tbl[3] = '{8'h01, 100};
        tbl[4] = '{8'h80, 20};
        tbl[5] = '{8'h5A, 70};
        exp36  = '{7, 5, 2, 1};

        rst       = 1'b1;
        load      = 1'b0;
        D         = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_y", Y, 0);
        check("rst_zero", zero, 0);
        tick();
        tick();
        rst = 1'b0;

        // Stall three cycles on 0x81, then release.
        do_load(8'h81);
        for (int i = 0; i < 3; i++) begin
            check("stall81_valid", out_valid, 1);
            check("stall81_y", Y, 7);
            tick();
        end
        out_ready = 1'b1;
        check("r81_y7", Y, 7);
        tick();
        check("r81_valid", out_valid, 1);
        check("r81_y0", Y, 0);
        tick();
        check("r81_idle", in_ready, 1);
        check("r81_done", out_valid, 0);
        out_ready = 1'b0;

        // Back-to-back serve of 1010_0110.
        do_load(8'hA6);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("a6_valid", out_valid, 1);
            check("a6_y", Y, exp36[i]);
            tick();
        end
        check("a6_idle", in_ready, 1);
        check("a6_done", out_valid, 0);
        check("a6_y_idle", Y, 0);
        out_ready = 1'b0;
        exp_q.delete();

        // All-zero load pulses zero for one cycle only.
        do_load(8'h00);
        check("z_valid", out_valid, 0);
        check("z_ready", in_ready, 1);
        tick();
        check("z_clear", zero, 0);
        check("z_valid2", out_valid, 0);

        // Vector table; drain also drives dropped loads while scanning.
        for (int t = 0; t < 6; t++) begin
            do_load(tbl[t].d);
            drain(tbl[t].pct, hs);
            check("tbl_hs_count", hs, $countones(tbl[t].d));
        end

        // Reset after two of four handshakes of 0x0F.
        do_load(8'h0F);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("r0f_y", Y, exp_q.pop_front());
            tick();
        end
        rst = 1'b1;
        #1;
        check("r0f_async_valid", out_valid, 0);
        check("r0f_async_y", Y, 0);
        check("r0f_async_ready", in_ready, 1);
        exp_q.delete();
        mptr = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r0f_no_stale", out_valid, 0);
            check("r0f_y_zero", Y, 0);
        end
        out_ready = 1'b0;

        // Random nonzero loads against the model.
        for (int t = 0; t < 30; t++) begin
            d = N'($urandom_range(255, 1));
            do_load(d);
            drain($urandom_range(100, 25), hs);
            check("rnd_hs_count", hs, $countones(d));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
